escalonador_animacao: RTL
=========================

# escalonador_animacao

Sequences frame transmission from the image controller to the display serial driver. It sweeps the 10-bit `byte_counter` across the 1024-byte frame and absorbs the image controller's one-cycle registered read latency. It presents each byte to the driver with a valid/ready handshake and advances the per-state animation frame index. It sits between the Tamagotchi state logic, the image controller and the OLED serial transmitter.

## Interface
Parameters:
- `FRAMES_PER_STEP`, default 4: complete frames sent before the animation index advances (must be ≥1).
- `GAP_CYCLES`, default 1000: idle cycles between frames (must be ≥1).
- `IDLE_SIZE`/`DORMINDO_SIZE`/`COMENDO_SIZE`/`DANDO_AULA_SIZE`/`MORTO_SIZE`, defaults 6/4/5/7/8: animation length per state.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `estado` in 4: one-hot state; IDLE=0000, DORMINDO=0001, COMENDO=0010, DANDO_AULA=0100, MORTO=1000. Any other code is treated as IDLE.
- `pixel_data` in 8: image controller output, registered one cycle after `byte_counter`.
- `tx_ready` in 1: serial driver can accept a byte.
- `byte_counter` out 10: frame byte address, 0..1023.
- `frame_idx` out 3: current animation frame, 0..size-1.
- `tx_data` out 8: byte to the driver.
- `tx_valid` out 1: `tx_data` is valid.
- `frame_start` out 1: one-cycle pulse on the first FETCH of byte 0.
- `frame_done` out 1: one-cycle pulse after the byte-1023 handshake.

## Operation
- FSM states: GAP, FETCH, LATCH, PRESENT.
- **GAP**
  - `gap_cnt` counts 0..GAP_CYCLES-1.
  - On the last count, the FSM goes to FETCH.
  - On that same edge, `estado` is compared with the latched `estado_lat`. If they differ: `estado_lat`<=`estado`, `frame_idx`<=0, `step_cnt`<=0.
- **FETCH**
  - `byte_counter` holds the current address. The image controller registers the byte at the end of this cycle.
  - Next state is LATCH.
- **LATCH**
  - `tx_data`<=`pixel_data`, `tx_valid`<=1.
  - Next state is PRESENT.
- **PRESENT**
  - `tx_data`, `tx_valid` and `byte_counter` stay stable until `tx_valid && tx_ready`.
  - On handshake: `tx_valid`<=0.
  - If `byte_counter`==1023: `byte_counter`<=0, `frame_done`<=1, `gap_cnt`<=0, go to GAP, and do the frame accounting below.
  - Otherwise: `byte_counter`+1, go to FETCH.
- **Frame accounting** (on the byte-1023 handshake):
  - If `step_cnt`==FRAMES_PER_STEP-1: `step_cnt`<=0 and `frame_idx`<=(`frame_idx`+1) mod size(`estado_lat`), wrapping from size-1 to 0.
  - Otherwise `step_cnt`+1.
- **Widths:** `step_cnt` uses clog2(FRAMES_PER_STEP) bits (min 1); `gap_cnt` uses clog2(GAP_CYCLES) bits (min 1). The index wrap is an explicit compare, not a modulo operator.
- **Mid-frame `estado` changes** are ignored until the next GAP→FETCH edge. A frame is never torn across animations.
- **Reset** (from any state, including mid-handshake):
  - FSM→GAP, `gap_cnt`=0, `estado_lat`=IDLE.
  - Outputs: `byte_counter`=0, `frame_idx`=0, `tx_data`=0, `tx_valid`=0, `frame_start`=0, `frame_done`=0, `step_cnt`=0.
  - Dropping `tx_valid` without a handshake is permitted only on reset.

## Timing
- All outputs are registered.
- Per byte: at least 3 cycles (FETCH, LATCH, PRESENT with `tx_ready`=1). Each cycle of `tx_ready`=0 in PRESENT adds 1 cycle.
- Frame with `tx_ready` held high: 1024×3 + GAP_CYCLES cycles.
- After reset release, `frame_start` occurs GAP_CYCLES cycles later.
- `frame_start` is high in the same cycle as the first FETCH of byte 0.
- `frame_done` is high the cycle after the byte-1023 handshake; `frame_idx` is updated in that same cycle.
- `tx_valid` rises on the edge leaving LATCH. It never falls before a handshake, except on reset.
- `tx_data` never changes while `tx_valid`=1 and `tx_ready`=0.

## Test plan
- **Reset, then idle:** `reset`=1 for 2 cycles with GAP_CYCLES=4 → all outputs 0; `frame_start` pulses exactly 4 cycles after release; `byte_counter`=0.
- **Latency and pass-through:** `tx_ready`=1, `pixel_data` = address[7:0] delayed one cycle → driver receives 0x00,0x01,…,0xFF,0x00… (1024 bytes), 3 cycles per byte, one `frame_done`.
- **Backpressure:** `tx_ready` low for 5 cycles on byte 17 → `tx_data`=0x11 and `tx_valid`=1 held stable for 5 cycles; no byte lost or duplicated; `byte_counter` stays 17.
- **Animation wrap:** `estado`=DORMINDO, FRAMES_PER_STEP=2, 10 frames → `frame_idx` sequence per frame is 0,0,1,1,2,2,3,3,0,0.
- **State change:** switch `estado` DANDO_AULA→MORTO at byte 500 while `frame_idx`=3 → rest of the frame keeps `frame_idx`=3; next `frame_start` has `frame_idx`=0 and MORTO latched. Then an illegal code 0011 → treated as IDLE, wrapping at 6.
- **Reset mid-frame:** `reset` at byte 700 while PRESENT with `tx_ready`=0 → next edge `tx_valid`=0, `byte_counter`=0, FSM in GAP; the next frame starts at byte 0.

Source files
------------

// File: rtl/escalonador_animacao.sv
// -----------------------------------------------------------------------------
// escalonador_animacao
//
// Sequences one 1024-byte frame at a time from the image controller to the
// OLED serial driver and steps the per-state animation frame index.
//
// Each byte takes FETCH -> LATCH -> PRESENT. FETCH puts the address on
// byte_counter. LATCH captures the image controller's registered byte.
// PRESENT holds the byte on a valid/ready handshake until the driver takes it.
// Frames are separated by GAP_CYCLES idle cycles. The animation state is only
// re-sampled at the GAP->FETCH edge, so a frame never mixes two animations.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   estado       in   one-hot Tamagotchi state (illegal codes act as IDLE)
//   pixel_data   in   image controller byte, one cycle behind byte_counter
//   tx_ready     in   serial driver can accept a byte
//   byte_counter out  frame byte address 0..1023
//   frame_idx    out  current animation frame 0..size-1
//   tx_data      out  byte presented to the driver
//   tx_valid     out  tx_data is valid
//   frame_start  out  one-cycle pulse on the FETCH of byte 0
//   frame_done   out  one-cycle pulse after the byte-1023 handshake
// -----------------------------------------------------------------------------
module escalonador_animacao #(
    parameter int FRAMES_PER_STEP = 4,
    parameter int GAP_CYCLES      = 1000,
    parameter int IDLE_SIZE       = 6,
    parameter int DORMINDO_SIZE   = 4,
    parameter int COMENDO_SIZE    = 5,
    parameter int DANDO_AULA_SIZE = 7,
    parameter int MORTO_SIZE      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] estado,
    input  logic [7:0] pixel_data,
    input  logic       tx_ready,
    output logic [9:0] byte_counter,
    output logic [2:0] frame_idx,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       frame_start,
    output logic       frame_done
);

    localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [9:0]        LAST_BYTE = 10'd1023;

    typedef enum logic [1:0] {
        S_GAP,
        S_FETCH,
        S_LATCH,
        S_PRESENT
    } state_t;

    typedef enum logic [2:0] {
        A_IDLE,
        A_DORMINDO,
        A_COMENDO,
        A_DANDO_AULA,
        A_MORTO
    } anim_t;

    state_t              r_state;
    anim_t               r_estado_lat;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [STEP_W-1:0]   r_step_cnt;
    logic [9:0]          r_byte_counter;
    logic [2:0]          r_frame_idx;
    logic [7:0]          r_tx_data;
    logic                r_tx_valid;
    logic                r_frame_start;
    logic                r_frame_done;

    anim_t               w_estado_dec;
    logic [2:0]          w_last_idx;
    logic [2:0]          w_next_idx;

    // Decode the one-hot input; anything that is not a legal code is IDLE.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_estado_dec = A_IDLE;
        case (estado)
            4'b0001: w_estado_dec = A_DORMINDO;
            4'b0010: w_estado_dec = A_COMENDO;
            4'b0100: w_estado_dec = A_DANDO_AULA;
            4'b1000: w_estado_dec = A_MORTO;
            default: w_estado_dec = A_IDLE;
        endcase
    end

    // Highest frame index of the latched animation.
    always_comb begin
        w_last_idx = 3'(IDLE_SIZE - 1);
        case (r_estado_lat)
            A_DORMINDO:   w_last_idx = 3'(DORMINDO_SIZE - 1);
            A_COMENDO:    w_last_idx = 3'(COMENDO_SIZE - 1);
            A_DANDO_AULA: w_last_idx = 3'(DANDO_AULA_SIZE - 1);
            A_MORTO:      w_last_idx = 3'(MORTO_SIZE - 1);
            default:      w_last_idx = 3'(IDLE_SIZE - 1);
        endcase
    end

    // Wrap by compare, so non-power-of-two animation lengths cost no divider.
    assign w_next_idx = (r_frame_idx == w_last_idx) ? 3'd0 : r_frame_idx + 3'd1;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_GAP;
            r_estado_lat   <= A_IDLE;
            r_gap_cnt      <= '0;
            r_step_cnt     <= '0;
            r_byte_counter <= '0;
            r_frame_idx    <= '0;
            r_tx_data      <= '0;
            r_tx_valid     <= 1'b0;
            r_frame_start  <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            case (r_state)
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state       <= S_FETCH;
                        r_frame_start <= 1'b1;
                        // A new animation restarts from its first frame.
                        if (w_estado_dec != r_estado_lat) begin
                            r_estado_lat <= w_estado_dec;
                            r_frame_idx  <= '0;
                            r_step_cnt   <= '0;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                S_FETCH: begin
                    // The image controller registers the addressed byte now.
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_tx_data  <= pixel_data;
                    r_tx_valid <= 1'b1;
                    r_state    <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        if (r_byte_counter == LAST_BYTE) begin
                            r_byte_counter <= '0;
                            r_frame_done   <= 1'b1;
                            r_gap_cnt      <= '0;
                            r_state        <= S_GAP;
                            if (r_step_cnt == STEP_LAST) begin
                                r_step_cnt  <= '0;
                                r_frame_idx <= w_next_idx;
                            end else begin
                                r_step_cnt <= r_step_cnt + STEP_W'(1);
                            end
                        end else begin
                            r_byte_counter <= r_byte_counter + 10'd1;
                            r_state        <= S_FETCH;
                        end
                    end
                end
                default: r_state <= S_GAP;
            endcase
        end
    end

    assign byte_counter = r_byte_counter;
    assign frame_idx    = r_frame_idx;
    assign tx_data      = r_tx_data;
    assign tx_valid     = r_tx_valid;
    assign frame_start  = r_frame_start;
    assign frame_done   = r_frame_done;

endmodule
